i2c_slave_regmap: RTL and testbench

I2C_SLAVE_REGMAP -- requirements
Module: i2c_slave_regmap

---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_bus_sync.sv | 51 +++++
 rtl/i2c_slave_regmap.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regmap.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM states, default bus address and
// register pointer type, common to the I2C responder and the I2C master.
package i2c_pkg;

   // Width of the register pointer carried in the first data byte.
   localparam int PTR_W = 6;

   // Default 7-bit bus address of the register-map responder.
   localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h72;

   // Number of SCL rising edges that make up one byte.
   localparam logic [3:0] BITS_PER_BYTE = 4'd8;

   // Byte-level protocol states of the responder.
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8
   } i2c_state_e;

   typedef logic [PTR_W-1:0] ptr_t;

   // Post-increment of the register pointer, wrapping from the last
   // implemented register back to register 0.
   function automatic ptr_t ptr_next(input ptr_t p, input int nreg);
      if (int'(p) >= nreg - 1) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the raw SCL/SDA lines into the clk_50 domain and derives the
// SCL edge strobes and the START/STOP conditions from the synchronised
// samples. Strobes are combinational from the flops and last one cycle.
module i2c_bus_sync
   import i2c_pkg::*;
(
   input  logic clk_50,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   // _p0/_p1 are the two synchroniser stages, _p2 is the history flop
   // used only for edge detection.
   logic scl_p0, scl_p1, scl_p2;
   logic sda_p0, sda_p1, sda_p2;

   // Two-flop synchroniser plus history flop; reset to the idle-bus level.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= scl_in;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= sda_in;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   // Edge and bus-condition decode; START/STOP need SCL high on both samples.
   always_comb begin
      sda       = sda_p1;
      scl_rise  = scl_p1 & ~scl_p2;
      scl_fall  = ~scl_p1 & scl_p2;
      start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
      stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
   end

endmodule

// File: rtl/i2c_slave_regmap.sv
// I2C responder exposing a small byte-wide register file. The first byte
// of a write sets the register pointer; following bytes are written with
// pointer post-increment. Reads return bytes from the pointer onwards,
// also post-incrementing. SDA is only ever changed on SCL falling edges.
module i2c_slave_regmap
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT,
   parameter int         NREG       = 64
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             sda_oe,
   output logic             wr_stb,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   input  logic [PTR_W-1:0] dbg_addr,
   output logic [7:0]       dbg_data,
   output logic             busy
);

   // Synchronised bus view.
   logic sda;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   // FSM state.
   i2c_state_e state_q;
   i2c_state_e state_d;

   // Datapath registers.
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   ptr_t       ptr_q;
   logic       rw_q;
   logic       rdack_q;
   logic       sda_oe_q;
   logic [7:0] regfile [NREG];

   // Per-cycle control decoded from state and bus events.
   logic       sda_oe_d;
   logic       cnt_clr;
   logic       cnt_inc;
   logic       shift_in;
   logic       shift_out;
   logic       load_rd;
   logic       ptr_load;
   logic       wr_en;
   logic       rw_cap;
   logic       rdack_cap;

   logic       byte_done;
   logic       addr_match;
   logic [7:0] rd_byte;

   i2c_bus_sync u_sync (
      .clk_50    (clk_50),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign byte_done  = (bit_cnt == BITS_PER_BYTE);
   assign addr_match = (shreg[7:1] == SLAVE_ADDR);
   assign rd_byte    = regfile[ptr_q];
   assign dbg_data   = regfile[dbg_addr];
   assign sda_oe     = sda_oe_q;

   // FSM state register.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; START and STOP override any SCL edge in the same cycle.
   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = ST_ADDR;
      end else if (stop_det) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_ADDR: begin
               if (scl_fall && byte_done) begin
                  state_d = addr_match ? ST_ADDR_ACK : ST_IDLE;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  state_d = rw_q ? ST_RDATA : ST_PTR;
               end
            end
            ST_PTR: begin
               if (scl_fall && byte_done) begin
                  state_d = ST_PTR_ACK;
               end
            end
            ST_PTR_ACK: begin
               if (scl_fall) begin
                  state_d = ST_WDATA;
               end
            end
            ST_WDATA: begin
               if (scl_fall && byte_done) begin
                  state_d = ST_WDATA_ACK;
               end
            end
            ST_WDATA_ACK: begin
               if (scl_fall) begin
                  state_d = ST_WDATA;
               end
            end
            ST_RDATA: begin
               if (scl_fall && byte_done) begin
                  state_d = ST_RDATA_ACK;
               end
            end
            ST_RDATA_ACK: begin
               if (scl_fall) begin
                  state_d = rdack_q ? ST_IDLE : ST_RDATA;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output and datapath control decode; SDA drive changes only on SCL falls.
   always_comb begin
      sda_oe_d  = sda_oe_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      shift_in  = 1'b0;
      shift_out = 1'b0;
      load_rd   = 1'b0;
      ptr_load  = 1'b0;
      wr_en     = 1'b0;
      rw_cap    = 1'b0;
      rdack_cap = 1'b0;
      busy      = !(state_q == ST_IDLE || state_q == ST_ADDR);

      if (start_det || stop_det) begin
         // Abandon whatever byte was in flight and let go of the bus.
         cnt_clr  = 1'b1;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  shift_in = 1'b1;
                  cnt_inc  = 1'b1;
               end
               if (scl_fall && byte_done) begin
                  cnt_clr = 1'b1;
                  if (state_q == ST_ADDR) begin
                     sda_oe_d = addr_match;
                     rw_cap   = addr_match;
                  end else if (state_q == ST_PTR) begin
                     sda_oe_d = 1'b1;
                     ptr_load = 1'b1;
                  end else begin
                     sda_oe_d = 1'b1;
                     wr_en    = 1'b1;
                  end
               end
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  cnt_clr  = 1'b1;
                  sda_oe_d = 1'b0;
                  if (state_q == ST_ADDR_ACK && rw_q) begin
                     // First read byte goes out on the fall that ends the ACK.
                     load_rd  = 1'b1;
                     sda_oe_d = ~rd_byte[7];
                  end
               end
            end
            ST_RDATA: begin
               if (scl_rise) begin
                  cnt_inc = 1'b1;
               end
               if (scl_fall) begin
                  if (byte_done) begin
                     cnt_clr  = 1'b1;
                     sda_oe_d = 1'b0;
                  end else begin
                     shift_out = 1'b1;
                     sda_oe_d  = ~shreg[6];
                  end
               end
            end
            ST_RDATA_ACK: begin
               if (scl_rise) begin
                  rdack_cap = 1'b1;
               end
               if (scl_fall) begin
                  cnt_clr  = 1'b1;
                  sda_oe_d = 1'b0;
                  if (!rdack_q) begin
                     load_rd  = 1'b1;
                     sda_oe_d = ~rd_byte[7];
                  end
               end
            end
            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   // Bit counter, shift register, pointer, SDA drive and write strobe.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         ptr_q    <= '0;
         rw_q     <= 1'b0;
         rdack_q  <= 1'b1;
         sda_oe_q <= 1'b0;
         wr_stb   <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         sda_oe_q <= sda_oe_d;
         wr_stb   <= wr_en;

         if (cnt_clr) begin
            bit_cnt <= '0;
         end else if (cnt_inc) begin
            bit_cnt <= bit_cnt + 4'd1;
         end

         if (shift_in) begin
            shreg <= {shreg[6:0], sda};
         end else if (shift_out) begin
            shreg <= {shreg[6:0], 1'b0};
         end else if (load_rd) begin
            shreg <= rd_byte;
         end

         if (rw_cap) begin
            rw_q <= shreg[0];
         end
         if (rdack_cap) begin
            rdack_q <= sda;
         end

         // Bits [7:6] of the pointer byte are deliberately dropped.
         if (ptr_load) begin
            ptr_q <= shreg[PTR_W-1:0];
         end else if (wr_en || load_rd) begin
            ptr_q <= ptr_next(ptr_q, NREG);
         end

         if (wr_en) begin
            wr_addr <= ptr_q;
            wr_data <= shreg;
         end
      end
   end

   // Register file: cleared on reset, written once per completed data byte.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regfile[i] <= 8'h00;
         end
      end else if (wr_en) begin
         regfile[ptr_q] <= shreg;
      end
   end

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Directed bench for i2c_slave_regmap: a bit-banged I2C master on an
// open-drain SDA model, with expected values written out by hand.
module tb_i2c_slave_regmap;

   localparam int Q = 8;  // clk_50 cycles per quarter SCL period

   logic       clk_50 = 1'b0;
   logic       reset  = 1'b1;
   logic       scl_in = 1'b1;
   logic       m_sda  = 1'b1;
   logic       sda_oe;
   logic       wr_stb;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic [5:0] dbg_addr = 6'd0;
   logic [7:0] dbg_data;
   logic       busy;
   wire        sda_bus = m_sda & ~sda_oe;

   int n_vec  = 0;
   int n_fail = 0;

   // Event counters kept by monitors, read as deltas by the sequence.
   int stb_cycles  = 0;
   int oe_cycles   = 0;
   int busy_cycles = 0;

   i2c_slave_regmap dut (
      .clk_50   (clk_50),
      .reset    (reset),
      .scl_in   (scl_in),
      .sda_in   (sda_bus),
      .sda_oe   (sda_oe),
      .wr_stb   (wr_stb),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .busy     (busy)
   );

   always #10 clk_50 = ~clk_50;

   always @(posedge clk_50) begin
      if (wr_stb) stb_cycles <= stb_cycles + 1;
      if (sda_oe) oe_cycles <= oe_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic peek(input logic [5:0] a, output logic [7:0] d);
      dbg_addr = a;
      wait_cyc(1);
      d = dbg_data;
   endtask

   // One SCL clock with the master presenting b; s is the bus level at SCL high.
   task automatic clk_bit(input logic b, output logic s);
      m_sda = b;
      wait_cyc(Q);
      scl_in = 1'b1;
      wait_cyc(Q);
      s = sda_bus;
      wait_cyc(Q);
      scl_in = 1'b0;
      wait_cyc(Q);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      wait_cyc(Q);
      scl_in = 1'b1;
      wait_cyc(Q);
      m_sda = 1'b0;
      wait_cyc(Q);
      scl_in = 1'b0;
      wait_cyc(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wait_cyc(Q);
      scl_in = 1'b1;
      wait_cyc(Q);
      m_sda = 1'b1;
      wait_cyc(2 * Q);
   endtask

   // ack is the bus level at the 9th clock; oe_after is sda_oe once it has ended.
   task automatic send_byte(input logic [7:0] b, output logic ack, output logic oe_after);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, ack);
      oe_after = sda_oe;
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(mack, s);
   endtask

   initial begin
      logic       ack, oe;
      logic [7:0] d;
      int         s0, o0, b0;
      logic [7:0] all_or;

      // Reset state
      wait_cyc(5);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_wr_stb", wr_stb, 1'b0);
      check("rst_wr_addr", wr_addr, 6'd0);
      check("rst_wr_data", wr_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      wait_cyc(5);

      // Write 0xA5 to register 5
      s0 = stb_cycles;
      i2c_start();
      send_byte(8'hE4, ack, oe);
      check("w5_addr_ack", ack, 1'b0);
      check("w5_addr_ack_release", oe, 1'b0);
      check("w5_busy", busy, 1'b1);
      send_byte(8'h05, ack, oe);
      check("w5_ptr_ack", ack, 1'b0);
      send_byte(8'hA5, ack, oe);
      check("w5_data_ack", ack, 1'b0);
      check("w5_data_ack_release", oe, 1'b0);
      i2c_stop();
      check("w5_stb_cycles", stb_cycles - s0, 1);
      check("w5_wr_addr", wr_addr, 6'd5);
      check("w5_wr_data", wr_data, 8'hA5);
      check("w5_busy_after_stop", busy, 1'b0);
      peek(6'd5, d);
      check("w5_reg5", d, 8'hA5);

      // Pointer 0x3F then two bytes: second one wraps to register 0
      s0 = stb_cycles;
      i2c_start();
      send_byte(8'hE4, ack, oe);
      send_byte(8'h3F, ack, oe);
      send_byte(8'h11, ack, oe);
      send_byte(8'h22, ack, oe);
      check("wrap_data_ack", ack, 1'b0);
      i2c_stop();
      check("wrap_stb_cycles", stb_cycles - s0, 2);
      check("wrap_wr_addr", wr_addr, 6'd0);
      peek(6'd63, d);
      check("wrap_reg63", d, 8'h11);
      peek(6'd0, d);
      check("wrap_reg0", d, 8'h22);

      // Pointer byte 0xC6: top bits dropped, lands in register 6
      i2c_start();
      send_byte(8'hE4, ack, oe);
      send_byte(8'hC6, ack, oe);
      check("ptrmask_ack", ack, 1'b0);
      send_byte(8'h5A, ack, oe);
      i2c_stop();
      check("ptrmask_wr_addr", wr_addr, 6'd6);
      peek(6'd6, d);
      check("ptrmask_reg6", d, 8'h5A);

      // Set pointer 5, repeated START, read two bytes (ACK then NACK)
      i2c_start();
      send_byte(8'hE4, ack, oe);
      send_byte(8'h05, ack, oe);
      i2c_start();
      send_byte(8'hE5, ack, oe);
      check("rd_addr_ack", ack, 1'b0);
      recv_byte(1'b0, d);
      check("rd_byte0", d, 8'hA5);
      recv_byte(1'b1, d);
      check("rd_byte1", d, 8'h5A);
      check("rd_nack_sda_oe", sda_oe, 1'b0);
      check("rd_nack_busy", busy, 1'b0);
      i2c_stop();

      // Foreign address 0x50: ignored entirely
      s0 = stb_cycles;
      o0 = oe_cycles;
      b0 = busy_cycles;
      i2c_start();
      send_byte(8'hA0, ack, oe);
      check("foreign_no_ack", ack, 1'b1);
      send_byte(8'h07, ack, oe);
      check("foreign_data_no_ack", ack, 1'b1);
      i2c_stop();
      check("foreign_oe_cycles", oe_cycles - o0, 0);
      check("foreign_busy_cycles", busy_cycles - b0, 0);
      check("foreign_stb_cycles", stb_cycles - s0, 0);

      // STOP after four data bits: byte discarded
      s0 = stb_cycles;
      i2c_start();
      send_byte(8'hE4, ack, oe);
      send_byte(8'h10, ack, oe);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, ack);
      i2c_stop();
      check("abort_stb_cycles", stb_cycles - s0, 0);
      check("abort_busy", busy, 1'b0);
      check("abort_sda_oe", sda_oe, 1'b0);
      peek(6'h10, d);
      check("abort_reg10", d, 8'h00);
      peek(6'd5, d);
      check("abort_reg5_kept", d, 8'hA5);

      // Reset during the second read bit of 0xA5 (bit value 0, SDA driven)
      i2c_start();
      send_byte(8'hE4, ack, oe);
      send_byte(8'h05, ack, oe);
      i2c_start();
      send_byte(8'hE5, ack, oe);
      clk_bit(1'b1, ack);
      check("rst_rd_bit1", ack, 1'b1);
      m_sda = 1'b1;
      wait_cyc(Q);
      scl_in = 1'b1;
      wait_cyc(Q);
      check("rst_rd_bit2_driven", sda_oe, 1'b1);
      reset = 1'b1;
      wait_cyc(1);
      check("rst_mid_sda_oe", sda_oe, 1'b0);
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(4);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_wr_data", wr_data, 8'h00);
      all_or = 8'h00;
      for (int i = 0; i < 64; i++) begin
         peek(6'(i), d);
         all_or = all_or | d;
      end
      check("rst_mid_regfile_clear", all_or, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
